// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - write-back arbiter request/response bus
interface regfile_wb_arbiter_if #(
  parameter int mem_width = 32,
  parameter int mem_depth = 32
);
  localparam int rd_w = $clog2(mem_depth);

  logic                 alu_valid;
  logic [rd_w-1:0]      alu_rd;
  logic [mem_width-1:0] alu_data;
  logic                 alu_stall;
  logic                 lsu_valid;
  logic                 lsu_ready;
  logic [rd_w-1:0]      lsu_rd;
  logic [mem_width-1:0] lsu_data;
  logic                 we;
  logic [mem_depth-1:0] wr_sel;
  logic [mem_width-1:0] data_in;
  logic [mem_depth-1:0] pending_mask;

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_stall, lsu_ready, we, wr_sel, data_in, pending_mask
  );

  // Requester / observer side
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_stall, lsu_ready, we, wr_sel, data_in, pending_mask
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - merges ALU and load-return write-backs into one register write port
module regfile_wb_arbiter #(
  parameter int mem_width    = 32,
  parameter int mem_depth    = 32,
  parameter int fifo_depth   = 2,
  parameter int starve_limit = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  regfile_wb_arbiter_if.slave io_wb
);
  localparam int rd_w  = $clog2(mem_depth);
  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = $clog2(fifo_depth + 1);
  localparam int stv_w = $clog2(starve_limit + 1);

  logic [rd_w-1:0]      r_fifo_rd   [fifo_depth];
  logic [mem_width-1:0] r_fifo_data [fifo_depth];
  logic [ptr_w-1:0]     r_wptr;
  logic [ptr_w-1:0]     r_rptr;
  logic [cnt_w-1:0]     r_count;
  logic [stv_w-1:0]     r_starve;
  logic                 r_we;
  logic [mem_depth-1:0] r_wr_sel;
  logic [mem_width-1:0] r_data_in;

  logic                 w_empty;
  logic                 w_ready;
  logic                 w_stall;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_grant_alu;
  logic                 w_grant_fifo;
  logic [rd_w-1:0]      w_rd;
  logic [mem_width-1:0] w_data;
  logic [mem_depth-1:0] w_pending;

  assign w_empty = (r_count == '0);
  assign w_ready = (r_count < cnt_w'(fifo_depth));
  // The counter only reaches the limit while the FIFO holds something,
  // so a stall always has a head entry to hand the port to.
  assign w_stall      = (r_starve == stv_w'(starve_limit));
  assign w_grant_fifo = !w_empty && (w_stall || !io_wb.alu_valid);
  assign w_grant_alu  = !w_stall && io_wb.alu_valid;
  assign w_push       = io_wb.lsu_valid && w_ready && !i_reset;
  assign w_pop        = w_grant_fifo;
  assign w_rd         = w_grant_fifo ? r_fifo_rd[r_rptr]   : io_wb.alu_rd;
  assign w_data       = w_grant_fifo ? r_fifo_data[r_rptr] : io_wb.alu_data;

  // Destinations still in flight: live FIFO entries plus the output register
  always_comb begin
    w_pending = r_wr_sel;
    for (int i = 0; i < fifo_depth; i++) begin
      if (cnt_w'(i) < r_count) begin
        w_pending[r_fifo_rd[r_rptr + ptr_w'(i)]] = 1'b1;
      end
    end
    w_pending[0] = 1'b0;
  end

  // FIFO payload storage; contents are don't-care outside the live window
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= io_wb.lsu_rd;
      r_fifo_data[r_wptr] <= io_wb.lsu_data;
    end
  end

  // FIFO pointers, occupancy and starvation counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + ptr_w'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + cnt_w'(1);
        2'b01:   r_count <= r_count - cnt_w'(1);
        default: r_count <= r_count;
      endcase
      // Popping is the only way the FIFO drains, so it also covers "became empty"
      if (w_pop) begin
        r_starve <= '0;
      end else if (w_grant_alu && !w_empty) begin
        r_starve <= r_starve + stv_w'(1);
      end
    end
  end

  // Registered write port; x0 writes are consumed but never reach storage
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_we      <= 1'b0;
      r_wr_sel  <= '0;
      r_data_in <= '0;
    end else if ((w_grant_alu || w_grant_fifo) && (w_rd != '0)) begin
      r_we      <= 1'b1;
      r_wr_sel  <= mem_depth'(1) << w_rd;
      r_data_in <= w_data;
    end else begin
      r_we     <= 1'b0;
      r_wr_sel <= '0;
    end
  end

  assign io_wb.alu_stall    = w_stall;
  assign io_wb.lsu_ready    = w_ready;
  assign io_wb.we           = r_we;
  assign io_wb.wr_sel       = r_wr_sel;
  assign io_wb.data_in      = r_data_in;
  assign io_wb.pending_mask = w_pending;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int MW = 32;
  localparam int MD = 32;
  localparam int FD = 2;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.mem_width(MW), .mem_depth(MD)) bus ();

  regfile_wb_arbiter #(
    .mem_width(MW), .mem_depth(MD), .fifo_depth(FD), .starve_limit(SL)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .io_wb  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of pending loads plus the expected output register
  int          q_rd[$];
  logic [31:0] q_data[$];
  int          m_starve;
  logic        m_we;
  logic [31:0] m_sel;
  logic [31:0] m_data;

  typedef struct {
    logic        av;
    int          ard;
    logic [31:0] ad;
    logic        lv;
    int          lrd;
    logic [31:0] ld;
    logic [31:0] e_we;
    logic [31:0] e_sel;
    logic [31:0] e_data;
    logic [31:0] e_pend;
    logic [31:0] e_ready;
    logic [31:0] e_stall;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input int ard, input logic [31:0] ad,
                       input logic lv, input int lrd, input logic [31:0] ld);
    bus.alu_valid = av;
    bus.alu_rd    = 5'(ard);
    bus.alu_data  = ad;
    bus.lsu_valid = lv;
    bus.lsu_rd    = 5'(lrd);
    bus.lsu_data  = ld;
  endtask

  function automatic logic [31:0] m_pending();
    logic [31:0] p;
    p = m_sel;
    foreach (q_rd[i]) p[q_rd[i]] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic model_reset();
    q_rd.delete();
    q_data.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_sel    = '0;
    m_data   = '0;
  endtask

  // Compare DUT against the model for this cycle, then advance the model over the coming edge
  task automatic model_check_and_step();
    logic        stall, nonempty, take_fifo, take_alu, can_push;
    int          rd;
    logic [31:0] d;
    check("m_we",      bus.we,           m_we);
    check("m_wr_sel",  bus.wr_sel,       m_sel);
    check("m_data_in", bus.data_in,      m_data);
    check("m_pending", bus.pending_mask, m_pending());
    check("m_ready",   bus.lsu_ready,    (q_rd.size() < FD));
    check("m_stall",   bus.alu_stall,    (m_starve == SL));
    if (rst) begin
      model_reset();
      return;
    end
    stall     = (m_starve == SL);
    nonempty  = (q_rd.size() > 0);
    take_fifo = nonempty && (stall || !bus.alu_valid);
    take_alu  = !stall && bus.alu_valid;
    can_push  = bus.lsu_valid && (q_rd.size() < FD);
    if (take_fifo) begin
      rd = q_rd.pop_front();
      d  = q_data.pop_front();
    end else begin
      rd = int'(bus.alu_rd);
      d  = bus.alu_data;
    end
    if ((take_fifo || take_alu) && rd != 0) begin
      m_we   = 1'b1;
      m_sel  = 32'd1 << rd;
      m_data = d;
    end else begin
      m_we  = 1'b0;
      m_sel = '0;
    end
    if (take_fifo) m_starve = 0;
    else if (take_alu && nonempty) m_starve = m_starve + 1;
    if (can_push) begin
      q_rd.push_back(int'(bus.lsu_rd));
      q_data.push_back(bus.lsu_data);
    end
  endtask

  // Called #1 after the negedge with inputs already driven
  task automatic tick();
    model_check_and_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen[$];
    int pushes;
    int lsu_items[3];

    tbl[0] = '{1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 32'h0,  0, 32'h00, 32'h00000000, 32'h00, 1, 0};
    tbl[1] = '{1'b0, 0, 32'h0,        1'b0, 0, 32'h0,  1, 32'h20, 32'hDEADBEEF, 32'h20, 1, 0};
    tbl[2] = '{1'b1, 3, 32'h11,       1'b1, 7, 32'h22, 0, 32'h00, 32'hDEADBEEF, 32'h00, 1, 0};
    tbl[3] = '{1'b0, 0, 32'h0,        1'b0, 0, 32'h0,  1, 32'h08, 32'h00000011, 32'h88, 1, 0};
    tbl[4] = '{1'b0, 0, 32'h0,        1'b0, 0, 32'h0,  1, 32'h80, 32'h00000022, 32'h80, 1, 0};
    tbl[5] = '{1'b0, 0, 32'h0,        1'b0, 0, 32'h0,  0, 32'h00, 32'h00000022, 32'h00, 1, 0};
    tbl[6] = '{1'b1, 0, 32'h55,       1'b1, 0, 32'h66, 0, 32'h00, 32'h00000022, 32'h00, 1, 0};
    tbl[7] = '{1'b0, 0, 32'h0,        1'b0, 0, 32'h0,  0, 32'h00, 32'h00000022, 32'h00, 1, 0};
    tbl[8] = '{1'b0, 0, 32'h0,        1'b0, 0, 32'h0,  0, 32'h00, 32'h00000022, 32'h00, 1, 0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Directed vectors: ALU-only, collision, rd=0
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].lv, tbl[i].lrd, tbl[i].ld);
      #1;
      check($sformatf("vec%0d_we", i),      bus.we,           tbl[i].e_we);
      check($sformatf("vec%0d_wr_sel", i),  bus.wr_sel,       tbl[i].e_sel);
      check($sformatf("vec%0d_data_in", i), bus.data_in,      tbl[i].e_data);
      check($sformatf("vec%0d_pending", i), bus.pending_mask, tbl[i].e_pend);
      check($sformatf("vec%0d_ready", i),   bus.lsu_ready,    tbl[i].e_ready);
      check($sformatf("vec%0d_stall", i),   bus.alu_stall,    tbl[i].e_stall);
      tick();
    end

    // FIFO full under continuous ALU traffic: three loads, order preserved
    lsu_items = '{10, 11, 12};
    pushes = 0;
    for (int c = 0; c < 30; c++) begin
      if (pushes < 3) drive(c < 20, 1, 32'h1000 + c, 1, lsu_items[pushes], 32'hA0 + lsu_items[pushes]);
      else            drive(c < 20, 1, 32'h1000 + c, 0, 0, 0);
      #1;
      if (c == 2) check("full_ready_low", bus.lsu_ready, 0);
      if (bus.we) begin
        for (int b = 10; b <= 12; b++) begin
          if (bus.wr_sel[b]) begin
            seen.push_back(b);
            check("full_data", bus.data_in, 32'hA0 + b);
          end
        end
      end
      if (bus.lsu_valid && bus.lsu_ready) pushes++;
      tick();
    end
    check("full_push_count", pushes, 3);
    check("full_write_count", seen.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < seen.size()) check($sformatf("full_order%0d", i), seen[i], lsu_items[i]);
    end

    // Starvation: rd=9 waits behind a continuously valid ALU
    for (int s = 0; s < 12; s++) begin
      drive(1, 2, 32'h100, s == 0, 9, 32'h99);
      #1;
      if (s < 5 || s > 5) check($sformatf("starve_stall%0d", s), bus.alu_stall, (s == 5));
      if (s == 5) check("starve_stall_on", bus.alu_stall, 1);
      if (s == 6) begin
        check("starve_we", bus.we, 1);
        check("starve_sel", bus.wr_sel, 32'h200);
        check("starve_data", bus.data_in, 32'h99);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    tick();

    // Reset in the middle of a backlog
    drive(1, 3, 32'h33, 1, 20, 32'h1);
    #1;
    tick();
    drive(1, 3, 32'h33, 1, 21, 32'h2);
    #1;
    tick();
    rst = 1'b1;
    drive(1, 3, 32'h33, 1, 22, 32'h3);
    #1;
    check("rst_pending_before", bus.pending_mask, 32'h0030_0008);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 6; r++) begin
      #1;
      check($sformatf("rst_we%0d", r), bus.we, 0);
      check($sformatf("rst_ready%0d", r), bus.lsu_ready, 1);
      check($sformatf("rst_pending%0d", r), bus.pending_mask, 0);
      check($sformatf("rst_stall%0d", r), bus.alu_stall, 0);
      tick();
    end

    // Randomized traffic against the model, with occasional resets
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(63) == 0);
      drive($urandom_range(9) < 7, $urandom_range(31), $urandom(),
            $urandom_range(1), $urandom_range(31), $urandom());
      #1;
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back arbitration stage directly upstream of the 32x32 negedge-write register storage block.
- Merges two write-back sources into the storage block's single write port (we, wr_sel, data_in):
  - ALU commit path, fixed priority.
  - Load/store return path, which has a ready handshake.
- Load returns are buffered in a small FIFO and drained in idle ALU slots, with a starvation guard.
- Publishes a pending-destination mask so decode can stall on in-flight writes.

Parameters:
- mem_width, 32, data width of one register.
- mem_depth, 32, number of architectural registers; width of wr_sel and pending_mask; rd index width is log2(mem_depth).
- fifo_depth, 2, load-return buffer entries (power of two, >=2).
- starve_limit, 4, consecutive ALU-won cycles with a non-empty FIFO before the ALU is stalled for one cycle.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU write-back request; ignored while alu_stall=1.
- alu_rd  in  5  ALU destination register.
- alu_data  in  mem_width  ALU result.
- alu_stall  out  1  ALU must hold its request this cycle.
- lsu_valid  in  1  load-return request.
- lsu_ready  out  1  FIFO can accept; a transfer occurs when lsu_valid & lsu_ready.
- lsu_rd  in  5  load destination register.
- lsu_data  in  mem_width  load data.
- we  out  1  registered write enable to the storage block.
- wr_sel  out  mem_depth  registered one-hot destination select.
- data_in  out  mem_width  registered write data.
- pending_mask  out  mem_depth  destinations in flight (FIFO entries plus output register).

Behaviour:
- Reset: we=0, wr_sel=0, data_in=0, FIFO count=0, read/write pointers=0, starve counter=0, alu_stall=0, pending_mask=0. Any in-flight FIFO entries are discarded.
- FIFO:
  - lsu_ready = (count < fifo_depth). It does not depend on a same-cycle pop.
  - Push on lsu_valid & lsu_ready.
  - Pop when the FIFO is non-empty and the port is granted to the FIFO.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo fifo_depth.
- Grant (combinational, each cycle):
  - alu_stall=1 -> FIFO head granted.
  - Otherwise alu_valid=1 -> ALU granted.
  - Otherwise FIFO non-empty -> head granted.
  - Otherwise no grant.
- Output register (posedge):
  - Granted entry with rd!=0: we=1, wr_sel=1<<rd, data_in=data.
  - Granted entry with rd==0: consumed (ALU accepted / FIFO popped), but we=0, wr_sel=0.
  - No grant: we=0, wr_sel=0, data_in holds its previous value.
- Latency:
  - ALU: request in cycle N -> we high in cycle N+1.
  - LSU: pushed at the edge ending cycle N -> earliest we in cycle N+2 (head granted in cycle N+1).
  - There is no LSU bypass around the FIFO.
- Starve counter:
  - Increments when the ALU is granted while the FIFO is non-empty.
  - Clears when the FIFO is popped or becomes empty.
  - When it equals starve_limit, alu_stall=1 for exactly that cycle (combinational from the counter). The FIFO head pops, and the counter clears at the next edge.
  - The ALU must present the same request again in the following cycle.
- pending_mask: OR of (1<<rd) over valid FIFO entries and wr_sel of the output register; bit 0 forced 0. Combinational from registered state only.
- Ordering: ALU and LSU writes to the same rd are not reordered by this block beyond grant order. Issue logic uses pending_mask to prevent WAW across sources.
- Reset mid-operation: FIFO flushed, any held stall dropped; an lsu_valid present in the reset cycle is not accepted.

Test Plan:
- ALU only: alu_valid=1, alu_rd=5, alu_data=32'hDEADBEEF in cycle 1 -> cycle 2: we=1, wr_sel=32'h20, data_in=32'hDEADBEEF; cycle 3 with no request: we=0.
- Collision: cycle 1 alu(rd=3, 32'h11) and lsu(rd=7, 32'h22) both valid -> cycle 2: write x3 and pending_mask bit7=1 (plus bit3 from output register); cycle 3 alu idle -> x7 written; cycle 4: pending_mask=0.
- FIFO full: ALU valid every cycle with fifo_depth=2 and three LSU pushes -> lsu_ready=0 after two pushes until a pop. No entry is lost or duplicated, and write order equals push order.
- Starvation: FIFO holds rd=9 while ALU is valid continuously -> alu_stall=1 on the 5th cycle (4 ALU grants first), x9 written the next cycle, counter back to 0.
- rd=0: alu_rd=0 and an lsu push with rd=0 -> both consumed, we never asserted, pending_mask bit0 always 0.
- Reset mid-drain: FIFO holding 2 entries, assert reset for one cycle -> next cycle we=0, lsu_ready=1, pending_mask=0, and no stale write afterwards.
